// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the 8080-style parallel LCD bus engines.
// Contents:
//   lcd_state_e         - phase encoding of the read-back engine
//   LCD_*_CYC           - default bus timing, shared with the write path so
//                         both controllers meet the same panel tWRL/tRDL
//   LCD_IDLE_*          - levels driven onto the bus when nobody owns it
//   lcd_max/lcd_timer_w - sizing helpers for the phase timer
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD_LO = 3'd1,
        ST_CMD_HI = 3'd2,
        ST_TURN   = 3'd3,
        ST_RD_LO  = 3'd4,
        ST_RD_HI  = 3'd5
    } lcd_state_e;

    localparam int unsigned LCD_WR_LOW_CYC  = 1;
    localparam int unsigned LCD_WR_HIGH_CYC = 1;
    localparam int unsigned LCD_TURN_CYC    = 2;
    localparam int unsigned LCD_RD_LOW_CYC  = 4;
    localparam int unsigned LCD_RD_HIGH_CYC = 3;

    localparam logic LCD_IDLE_CS = 1'b1;
    localparam logic LCD_IDLE_RS = 1'b1;
    localparam logic LCD_IDLE_WR = 1'b1;
    localparam logic LCD_IDLE_RD = 1'b1;
    localparam logic LCD_IDLE_OE = 1'b0;

    function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The timer holds (phase length - 1), so the longest phase m needs
    // enough bits to represent m-1.
    function automatic int unsigned lcd_timer_w(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d,
                                                input int unsigned e);
        int unsigned m;
        m = lcd_max(lcd_max(lcd_max(a, b), lcd_max(c, d)), e);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that measures bus phase lengths.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears the count
//   load - load len (phase length - 1) this cycle
//   len  - value to load
//   zero - count has reached 0, i.e. the current phase ends this cycle
module lcd_phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = len;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_reg_reader.sv
// Read-back engine for the 8080 parallel LCD bus: writes one command word,
// releases the bus, then issues rd_len RD strobes and returns each word.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - request, sampled only while idle
//   cmd, rd_len, rd_skip- command word, number of reads, drop first word
//   busy                - bus owned by this block
//   done                - one-cycle pulse in the first idle cycle after a transaction
//   rd_data, rd_valid   - last captured word and its update pulse
//   LCD_CS/RS/WR/RD     - bus controls (active-low except RS)
//   LCD_DATA_O/_OE/_I   - bus data out, drive enable, data in
module lcd_reg_reader
    import lcd_bus_pkg::*;
#(
    parameter int unsigned WR_LOW_CYC  = LCD_WR_LOW_CYC,
    parameter int unsigned WR_HIGH_CYC = LCD_WR_HIGH_CYC,
    parameter int unsigned TURN_CYC    = LCD_TURN_CYC,
    parameter int unsigned RD_LOW_CYC  = LCD_RD_LOW_CYC,
    parameter int unsigned RD_HIGH_CYC = LCD_RD_HIGH_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cmd,
    input  logic [3:0]  rd_len,
    input  logic        rd_skip,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        LCD_CS,
    output logic        LCD_RS,
    output logic        LCD_WR,
    output logic        LCD_RD,
    output logic [15:0] LCD_DATA_O,
    output logic        LCD_DATA_OE,
    input  logic [15:0] LCD_DATA_I
);

    localparam int unsigned TW = lcd_timer_w(WR_LOW_CYC, WR_HIGH_CYC, TURN_CYC,
                                             RD_LOW_CYC, RD_HIGH_CYC);

    localparam logic [TW-1:0] WRL_M1 = TW'(WR_LOW_CYC - 1);
    localparam logic [TW-1:0] WRH_M1 = TW'(WR_HIGH_CYC - 1);
    localparam logic [TW-1:0] TRN_M1 = TW'(TURN_CYC - 1);
    localparam logic [TW-1:0] RDL_M1 = TW'(RD_LOW_CYC - 1);
    localparam logic [TW-1:0] RDH_M1 = TW'(RD_HIGH_CYC - 1);

    lcd_state_e    state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          skip_q, skip_d;
    logic          first_q, first_d;

    logic          cs_q, cs_d, rs_q, rs_d, wr_q, wr_d, rd_q, rd_d, oe_q, oe_d;
    logic [15:0]   dout_q, dout_d;
    logic          busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [15:0]   rdata_q, rdata_d;

    logic          capture;
    logic          t_zero;
    logic          t_load;
    logic [TW-1:0] t_len;

    lcd_phase_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (t_load),
        .len  (t_len),
        .zero (t_zero)
    );

    // Next-state logic: each phase lasts until the timer reports zero.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        first_d = first_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CMD_LO;
                    cmd_d   = cmd;
                    cnt_d   = rd_len;
                    skip_d  = rd_skip;
                    first_d = 1'b1;
                end
            end
            ST_CMD_LO: if (t_zero) state_d = ST_CMD_HI;
            ST_CMD_HI: if (t_zero) state_d = (cnt_q == 4'd0) ? ST_IDLE : ST_TURN;
            ST_TURN:   if (t_zero) state_d = ST_RD_LO;
            ST_RD_LO: begin
                if (t_zero) begin
                    state_d = ST_RD_HI;
                    capture = 1'b1;     // this edge raises RD; panel data is valid
                end
            end
            ST_RD_HI: begin
                if (t_zero) begin
                    cnt_d   = cnt_q - 4'd1;
                    first_d = 1'b0;
                    state_d = (cnt_q == 4'd1) ? ST_IDLE : ST_RD_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer reloads on every phase change with the length of the phase entered.
    always_comb begin
        t_load = (state_d != state_q);
        t_len  = '0;
        unique case (state_d)
            ST_CMD_LO: t_len = WRL_M1;
            ST_CMD_HI: t_len = WRH_M1;
            ST_TURN:   t_len = TRN_M1;
            ST_RD_LO:  t_len = RDL_M1;
            ST_RD_HI:  t_len = RDH_M1;
            default:   t_len = '0;
        endcase
    end

    // Bus outputs are decoded from the next state so the registered pins
    // line up with the state they belong to.
    always_comb begin
        cs_d    = LCD_IDLE_CS;
        rs_d    = LCD_IDLE_RS;
        wr_d    = LCD_IDLE_WR;
        rd_d    = LCD_IDLE_RD;
        oe_d    = LCD_IDLE_OE;
        dout_d  = '0;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        valid_d = capture && !(skip_q && first_q);
        rdata_d = valid_d ? LCD_DATA_I : rdata_q;
        unique case (state_d)
            ST_CMD_LO: begin
                cs_d = 1'b0; rs_d = 1'b0; wr_d = 1'b0; oe_d = 1'b1; dout_d = cmd_d;
            end
            ST_CMD_HI: begin
                cs_d = 1'b0; rs_d = 1'b0; oe_d = 1'b1; dout_d = cmd_d;
            end
            ST_TURN:  cs_d = 1'b0;
            ST_RD_LO: begin
                cs_d = 1'b0; rd_d = 1'b0;
            end
            ST_RD_HI: cs_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            skip_q  <= 1'b0;
            first_q <= 1'b0;
            cs_q    <= LCD_IDLE_CS;
            rs_q    <= LCD_IDLE_RS;
            wr_q    <= LCD_IDLE_WR;
            rd_q    <= LCD_IDLE_RD;
            oe_q    <= LCD_IDLE_OE;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            first_q <= first_d;
            cs_q    <= cs_d;
            rs_q    <= rs_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    assign LCD_CS      = cs_q;
    assign LCD_RS      = rs_q;
    assign LCD_WR      = wr_q;
    assign LCD_RD      = rd_q;
    assign LCD_DATA_OE = oe_q;
    assign LCD_DATA_O  = dout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_valid    = valid_q;
    assign rd_data     = rdata_q;

endmodule

// File: tb/tb_lcd_reg_reader.sv
module tb_lcd_reg_reader;

    localparam int unsigned WRL = 1, WRH = 1, TRN = 2, RDL = 4, RDH = 3;

    logic        clk = 1'b0;
    logic        rst, start, rd_skip;
    logic [15:0] cmd;
    logic [3:0]  rd_len;
    logic        busy, done, rd_valid;
    logic [15:0] rd_data;
    logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_OE;
    logic [15:0] LCD_DATA_O, LCD_DATA_I;

    always #5 clk = ~clk;

    lcd_reg_reader #(
        .WR_LOW_CYC(WRL), .WR_HIGH_CYC(WRH), .TURN_CYC(TRN),
        .RD_LOW_CYC(RDL), .RD_HIGH_CYC(RDH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .rd_len(rd_len),
        .rd_skip(rd_skip), .busy(busy), .done(done), .rd_data(rd_data),
        .rd_valid(rd_valid), .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR),
        .LCD_RD(LCD_RD), .LCD_DATA_O(LCD_DATA_O), .LCD_DATA_OE(LCD_DATA_OE),
        .LCD_DATA_I(LCD_DATA_I)
    );

    // ---------------- behavioural model: expected per-cycle bus waveform
    typedef struct packed {
        logic cs, rs, wr, rd, oe, busy, done, valid;
        logic [15:0] rdata;
        logic [15:0] dout;
    } rec_t;

    logic [15:0] panel [16];
    rec_t        mq[$];
    rec_t        cur = 40'hF0_0000_0000;
    logic [15:0] mlast = 16'h0;
    int          accepts = 0;
    longint      acc_time = 0;

    function automatic rec_t idle_rec(input logic [15:0] rdv, input logic dn);
        rec_t r;
        r.cs = 1'b1; r.rs = 1'b1; r.wr = 1'b1; r.rd = 1'b1; r.oe = 1'b0;
        r.busy = 1'b0; r.done = dn; r.valid = 1'b0; r.rdata = rdv; r.dout = 16'h0;
        return r;
    endfunction

    task automatic push_n(input rec_t r, input int unsigned n);
        for (int i = 0; i < int'(n); i++) mq.push_back(r);
    endtask

    // Waveform of one transaction laid out phase by phase, followed by the done cycle.
    task automatic build(input logic [15:0] c, input int n, input logic skip);
        rec_t r;
        r = idle_rec(mlast, 1'b0);
        r.cs = 1'b0; r.rs = 1'b0; r.wr = 1'b0; r.oe = 1'b1; r.busy = 1'b1; r.dout = c;
        push_n(r, WRL);
        r.wr = 1'b1;
        push_n(r, WRH);
        if (n > 0) begin
            r.rs = 1'b1; r.oe = 1'b0; r.dout = 16'h0;
            push_n(r, TRN);
            for (int i = 0; i < n; i++) begin
                r.rd = 1'b0;
                push_n(r, RDL);
                r.rd = 1'b1;
                if (!(skip && i == 0)) begin
                    mlast = panel[i]; r.rdata = mlast; r.valid = 1'b1;
                end
                mq.push_back(r);
                r.valid = 1'b0;
                push_n(r, RDH - 1);
            end
        end
        mq.push_back(idle_rec(mlast, 1'b1));
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mlast = 16'h0;
            cur = idle_rec(16'h0, 1'b0);
        end else if (!cur.busy && start) begin
            build(cmd, int'(rd_len), rd_skip);
            accepts++;
            acc_time = $time;
            cur = mq.pop_front();
        end else if (mq.size() > 0) begin
            cur = mq.pop_front();
        end else begin
            cur = idle_rec(mlast, 1'b0);
        end
    end

    // ---------------- checking and monitoring (all in the stimulus process)
    int          checks = 0, errors = 0;
    int          busy_cnt = 0, done_cnt = 0, vcnt = 0;
    longint      done_time = 0;
    logic [15:0] vals [64];
    int          pe_cyc = 0, last_oe = 0, rd_fall = 0, rd_rise = 0, wr_fall = 0, base = 0;
    logic        prev_rd = 1'b1, prev_wr = 1'b1, wr_rs = 1'b1;
    logic [15:0] wr_data = 16'h0;

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check();
        rec_t a, e;
        a.cs = LCD_CS; a.rs = LCD_RS; a.wr = LCD_WR; a.rd = LCD_RD; a.oe = LCD_DATA_OE;
        a.busy = busy; a.done = done; a.valid = rd_valid; a.rdata = rd_data;
        a.dout = cur.oe ? LCD_DATA_O : 16'h0;
        e = cur;
        if (!cur.oe) e.dout = 16'h0;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle t=%0t {cs,rs,wr,rd,oe,busy,done,valid,rdata,dout} actual=%h required=%h",
                     $time, a, e);
        end
        checks++;
        if (LCD_DATA_OE && !LCD_RD) begin
            errors++; $display("FAIL oe_rd_overlap t=%0t actual=1 required=0", $time);
        end
        checks++;
        if (!LCD_WR && !LCD_RD) begin
            errors++; $display("FAIL wr_rd_overlap t=%0t actual=1 required=0", $time);
        end
        if (busy) busy_cnt++;
        if (done) begin done_cnt++; done_time = $time; end
        if (rd_valid && vcnt < 64) begin vals[vcnt] = rd_data; vcnt++; end
    endtask

    // Runs just after each active edge: bus edge bookkeeping and the panel's data.
    task automatic post_edge();
        int idx;
        pe_cyc++;
        if (LCD_DATA_OE) last_oe = pe_cyc;
        if (prev_rd && !LCD_RD) begin
            rd_fall++;
            checks++;
            if (pe_cyc - last_oe - 1 < int'(TRN)) begin
                errors++;
                $display("FAIL turnaround actual=%0d required>=%0d", pe_cyc - last_oe - 1, TRN);
            end
        end
        if (!prev_rd && LCD_RD) rd_rise++;
        if (prev_wr && !LCD_WR) begin wr_fall++; wr_data = LCD_DATA_O; wr_rs = LCD_RS; end
        prev_rd = LCD_RD;
        prev_wr = LCD_WR;
        idx = rd_rise - base;
        LCD_DATA_I = (idx >= 0 && idx < 16) ? panel[idx] : 16'hBEEF;
    endtask

    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
        post_edge();
    endtask

    task automatic wait_done(input int bound);
        int d, n;
        d = done_cnt; n = 0;
        while (done_cnt == d && n < bound) begin step(); n++; end
        expect_eq("done_timeout", 32'(done_cnt != d), 32'd1);
    endtask

    task automatic pulse_start(input logic [15:0] c, input logic [3:0] n, input logic s);
        cmd = c; rd_len = n; rd_skip = s; start = 1'b1;
        step();
        start = 1'b0; cmd = 16'hFFFF; rd_len = 4'hF; rd_skip = ~s;
    endtask

    logic [15:0] exp_id [3];
    logic [15:0] exp_cl [3];
    int b0, v0, a0, d0, w0, r0, n;

    initial begin
        exp_id[0] = 16'h0000; exp_id[1] = 16'h0093; exp_id[2] = 16'h0041;
        exp_cl[0] = 16'h5555; exp_cl[1] = 16'h6666; exp_cl[2] = 16'h7777;
        for (int i = 0; i < 16; i++) panel[i] = 16'h0;
        rst = 1'b1; start = 1'b0; cmd = 16'h0; rd_len = 4'h0; rd_skip = 1'b0;
        LCD_DATA_I = 16'h0;
        repeat (3) step();
        rst = 1'b0;
        step();
        expect_eq("reset_cs", 32'(LCD_CS), 32'd1);
        expect_eq("reset_rd", 32'(LCD_RD), 32'd1);
        expect_eq("reset_oe", 32'(LCD_DATA_OE), 32'd0);
        expect_eq("reset_busy", 32'(busy), 32'd0);
        expect_eq("reset_rd_data", 32'(rd_data), 32'd0);

        // Read ID with dummy read, plus an ignored start in flight
        panel[0] = 16'hDEAD; panel[1] = 16'h0000; panel[2] = 16'h0093; panel[3] = 16'h0041;
        base = rd_rise; b0 = busy_cnt; v0 = vcnt; a0 = accepts;
        pulse_start(16'h00D3, 4'd4, 1'b1);
        repeat (10) step();
        pulse_start(16'h0004, 4'd1, 1'b0);
        wait_done(100);
        expect_eq("id_busy_cycles", 32'(busy_cnt - b0), 32'd32);
        expect_eq("id_done_cycle", 32'(int'((done_time - acc_time - 5) / 10) + 1), 32'd33);
        repeat (6) step();
        expect_eq("id_valid_count", 32'(vcnt - v0), 32'd3);
        for (int i = 0; i < 3; i++)
            expect_eq($sformatf("id_word%0d", i), 32'(vals[v0 + i]), 32'(exp_id[i]));
        expect_eq("ignored_start_accepts", 32'(accepts - a0), 32'd1);

        // Command-only write, then back-to-back read issued in its done cycle
        b0 = busy_cnt; w0 = wr_fall; r0 = rd_fall;
        pulse_start(16'h0011, 4'd0, 1'b0);
        n = 0;
        while (!done && n < 50) begin step(); n++; end
        expect_eq("cmd_done_seen", 32'(done), 32'd1);
        expect_eq("cmd_busy_cycles", 32'(busy_cnt - b0), 32'd2);
        expect_eq("cmd_wr_pulses", 32'(wr_fall - w0), 32'd1);
        expect_eq("cmd_rd_strobes", 32'(rd_fall - r0), 32'd0);
        expect_eq("cmd_wr_data", 32'(wr_data), 32'h0011);
        expect_eq("cmd_wr_rs", 32'(wr_rs), 32'd0);
        panel[0] = 16'hA5A5;
        base = rd_rise; v0 = vcnt;
        pulse_start(16'h00AA, 4'd1, 1'b0);
        b0 = busy_cnt;
        expect_eq("b2b_busy_next_cycle", 32'(busy), 32'd1);
        wait_done(60);
        expect_eq("b2b_busy_cycles", 32'(busy_cnt - b0), 32'd11);
        expect_eq("b2b_valid_count", 32'(vcnt - v0), 32'd1);
        expect_eq("b2b_word", 32'(vals[v0]), 32'hA5A5);

        // Reset during RD_LO of word 2
        panel[0] = 16'h1111; panel[1] = 16'h2222; panel[2] = 16'h3333; panel[3] = 16'h4444;
        base = rd_rise; r0 = rd_fall; v0 = vcnt;
        pulse_start(16'h0C0C, 4'd4, 1'b0);
        n = 0;
        while (!(rd_fall - r0 == 3 && !LCD_RD) && n < 100) begin step(); n++; end
        expect_eq("rst_window_reached", 32'(rd_fall - r0), 32'd3);
        d0 = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_eq("midrst_cs", 32'(LCD_CS), 32'd1);
        expect_eq("midrst_rd", 32'(LCD_RD), 32'd1);
        expect_eq("midrst_oe", 32'(LCD_DATA_OE), 32'd0);
        expect_eq("midrst_busy", 32'(busy), 32'd0);
        expect_eq("midrst_valid", 32'(rd_valid), 32'd0);
        expect_eq("midrst_done", 32'(done), 32'd0);
        expect_eq("midrst_words_before", 32'(vcnt - v0), 32'd2);
        repeat (4) step();
        expect_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        panel[0] = 16'h5555; panel[1] = 16'h6666; panel[2] = 16'h7777;
        base = rd_rise; v0 = vcnt; b0 = busy_cnt;
        pulse_start(16'h0D0D, 4'd3, 1'b0);
        wait_done(100);
        expect_eq("clean_busy_cycles", 32'(busy_cnt - b0), 32'd25);
        expect_eq("clean_valid_count", 32'(vcnt - v0), 32'd3);
        for (int i = 0; i < 3; i++)
            expect_eq($sformatf("clean_word%0d", i), 32'(vals[v0 + i]), 32'(exp_cl[i]));

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
